ps2_keyboard_rx: RTL

PS2_KEYBOARD_RX -- requirements
Module: ps2_keyboard_rx

---
 rtl/ps2_keyboard_rx_if.sv | 47 ++++
 rtl/ps2_keyboard_rx.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keyboard_rx_if.sv
// rtl/ps2_keyboard_rx_if.sv - PS/2 keyboard receiver signal bundle
//
// Purpose : groups the raw PS/2 lines and the decoded byte/key outputs so the
//           receiver and its surroundings connect through one port.
// Signals : PS2_CLK, PS2_DATA      raw keyboard lines (driven by master)
//           RX_VALID, RX_DATA      good frame pulse / last good byte
//           RX_ERROR               bad start, parity, stop or timeout pulse
//           KEY_VALID, KEY_CODE    key event pulse / scan code
//           KEY_EXTENDED           event was prefixed by 0xE0
//           KEY_RELEASED           event was prefixed by 0xF0
// Modports: master - keyboard side (drives PS2_*, observes results)
//           slave  - receiver side
interface ps2_keyboard_rx_if;
    logic       PS2_CLK;
    logic       PS2_DATA;
    logic       RX_VALID;
    logic [7:0] RX_DATA;
    logic       RX_ERROR;
    logic       KEY_VALID;
    logic [7:0] KEY_CODE;
    logic       KEY_EXTENDED;
    logic       KEY_RELEASED;

    modport master (
        output PS2_CLK,
        output PS2_DATA,
        input  RX_VALID,
        input  RX_DATA,
        input  RX_ERROR,
        input  KEY_VALID,
        input  KEY_CODE,
        input  KEY_EXTENDED,
        input  KEY_RELEASED
    );

    modport slave (
        input  PS2_CLK,
        input  PS2_DATA,
        output RX_VALID,
        output RX_DATA,
        output RX_ERROR,
        output KEY_VALID,
        output KEY_CODE,
        output KEY_EXTENDED,
        output KEY_RELEASED
    );
endinterface

// File: rtl/ps2_keyboard_rx.sv
// rtl/ps2_keyboard_rx.sv - PS/2 keyboard frame receiver and scan-code decoder
//
// Purpose : synchronises and filters the PS/2 clock, receives 11-bit frames
//           (start, 8 data LSB first, odd parity, stop), flags bad frames and
//           inter-edge timeouts, and folds 0xE0/0xF0 prefixes into key events.
// Params  : FILTER_LEN     consecutive equal clock samples to accept a change
//           TIMEOUT_CYCLES max cycles between accepted falling edges in a frame
// Ports   : CLK_25MHZ      sole clock, rising edge
//           RESET          asynchronous active-high reset, released through a
//                          2-flop synchroniser
//           bus            ps2_keyboard_rx_if.slave (see interface file)
module ps2_keyboard_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 2500
) (
    input  logic             CLK_25MHZ,
    input  logic             RESET,
    ps2_keyboard_rx_if.slave bus
);
    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    // ------------------------------------------------------------------
    // Reset synchroniser: asserts immediately, deasserts after two edges.
    // ------------------------------------------------------------------
    logic rst_meta_q, rst_meta_d;
    logic rst_sync_q, rst_sync_d;
    logic rst;

    always_comb begin
        rst_meta_d = 1'b0;
        rst_sync_d = rst_meta_q;
    end

    always_ff @(posedge CLK_25MHZ or posedge RESET) begin
        if (RESET) begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= 1'b1;
        end else begin
            rst_meta_q <= rst_meta_d;
            rst_sync_q <= rst_sync_d;
        end
    end

    assign rst = rst_sync_q;

    // ------------------------------------------------------------------
    // Input synchronisers (idle PS/2 lines are high).
    // ------------------------------------------------------------------
    logic clk_meta_q, clk_meta_d, clk_sync_q, clk_sync_d;
    logic dat_meta_q, dat_meta_d, dat_sync_q, dat_sync_d;

    always_comb begin
        clk_meta_d = bus.PS2_CLK;
        clk_sync_d = clk_meta_q;
        dat_meta_d = bus.PS2_DATA;
        dat_sync_d = dat_meta_q;
    end

    // ------------------------------------------------------------------
    // Clock glitch filter. The filtered level only follows the
    // synchronised clock once it has disagreed for FILTER_LEN samples in a
    // row; any agreeing sample restarts the count.
    // ------------------------------------------------------------------
    logic           clk_filt_q, clk_filt_d;
    logic [FCW-1:0] filt_cnt_q, filt_cnt_d;
    logic           fall_edge;

    always_comb begin
        clk_filt_d = clk_filt_q;
        filt_cnt_d = '0;
        fall_edge  = 1'b0;
        if (clk_sync_q != clk_filt_q) begin
            if (filt_cnt_q == FCW'(FILTER_LEN - 1)) begin
                clk_filt_d = clk_sync_q;
                // level is about to go 1->0 when the current level is 1
                fall_edge  = clk_filt_q;
            end else begin
                filt_cnt_d = filt_cnt_q + FCW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM with inter-edge timeout.
    // ------------------------------------------------------------------
    state_t         state_q, state_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           parity_q, parity_d;
    logic [TCW-1:0] to_cnt_q, to_cnt_d;
    logic           rx_valid_q, rx_valid_d;
    logic           rx_error_q, rx_error_d;
    logic [7:0]     rx_data_q, rx_data_d;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        to_cnt_d   = to_cnt_q;
        rx_valid_d = 1'b0;
        rx_error_d = 1'b0;
        rx_data_d  = rx_data_q;

        // Counts cycles since the last accepted falling edge; held at zero
        // between frames and saturating rather than wrapping.
        if (state_q == IDLE || fall_edge) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != TCW'(TIMEOUT_CYCLES)) begin
            to_cnt_d = to_cnt_q + TCW'(1);
        end

        if (state_q != IDLE && !fall_edge && to_cnt_d == TCW'(TIMEOUT_CYCLES)) begin
            // keyboard stalled mid-frame: drop the partial byte
            state_d    = IDLE;
            bit_cnt_d  = '0;
            to_cnt_d   = '0;
            rx_error_d = 1'b1;
        end else if (fall_edge) begin
            unique case (state_q)
                IDLE: begin
                    if (!dat_sync_q) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end else begin
                        rx_error_d = 1'b1;
                    end
                end
                DATA: begin
                    shift_d   = {dat_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    parity_d = dat_sync_q;
                    state_d  = STOP;
                end
                STOP: begin
                    // odd parity: data + parity bit carry an odd number of ones
                    if (dat_sync_q && (^{shift_q, parity_q})) begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = shift_q;
                    end else begin
                        rx_error_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Scan-code decoder: prefixes set sticky flags, any other byte emits an
    // event tagged with them. An error drops the flags so a damaged
    // sequence can't tag the next key.
    // ------------------------------------------------------------------
    logic       ext_pend_q, ext_pend_d;
    logic       rel_pend_q, rel_pend_d;
    logic       key_valid_q, key_valid_d;
    logic [7:0] key_code_q, key_code_d;
    logic       key_ext_q, key_ext_d;
    logic       key_rel_q, key_rel_d;

    always_comb begin
        ext_pend_d  = ext_pend_q;
        rel_pend_d  = rel_pend_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        key_ext_d   = key_ext_q;
        key_rel_d   = key_rel_q;
        if (rx_error_q) begin
            ext_pend_d = 1'b0;
            rel_pend_d = 1'b0;
        end else if (rx_valid_q) begin
            if (rx_data_q == 8'hE0) begin
                ext_pend_d = 1'b1;
            end else if (rx_data_q == 8'hF0) begin
                rel_pend_d = 1'b1;
            end else begin
                key_valid_d = 1'b1;
                key_code_d  = rx_data_q;
                key_ext_d   = ext_pend_q;
                key_rel_d   = rel_pend_q;
                ext_pend_d  = 1'b0;
                rel_pend_d  = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_25MHZ or posedge rst) begin
        if (rst) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            dat_meta_q  <= 1'b1;
            dat_sync_q  <= 1'b1;
            clk_filt_q  <= 1'b1;
            filt_cnt_q  <= '0;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            to_cnt_q    <= '0;
            rx_valid_q  <= 1'b0;
            rx_error_q  <= 1'b0;
            rx_data_q   <= '0;
            ext_pend_q  <= 1'b0;
            rel_pend_q  <= 1'b0;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
            key_ext_q   <= 1'b0;
            key_rel_q   <= 1'b0;
        end else begin
            clk_meta_q  <= clk_meta_d;
            clk_sync_q  <= clk_sync_d;
            dat_meta_q  <= dat_meta_d;
            dat_sync_q  <= dat_sync_d;
            clk_filt_q  <= clk_filt_d;
            filt_cnt_q  <= filt_cnt_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            to_cnt_q    <= to_cnt_d;
            rx_valid_q  <= rx_valid_d;
            rx_error_q  <= rx_error_d;
            rx_data_q   <= rx_data_d;
            ext_pend_q  <= ext_pend_d;
            rel_pend_q  <= rel_pend_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            key_ext_q   <= key_ext_d;
            key_rel_q   <= key_rel_d;
        end
    end

    assign bus.RX_VALID     = rx_valid_q;
    assign bus.RX_DATA      = rx_data_q;
    assign bus.RX_ERROR     = rx_error_q;
    assign bus.KEY_VALID    = key_valid_q;
    assign bus.KEY_CODE     = key_code_q;
    assign bus.KEY_EXTENDED = key_ext_q;
    assign bus.KEY_RELEASED = key_rel_q;

endmodule
